fetch_cycle: RTL and testbench

Instruction-fetch stage directly upstream of the decode stage. It owns the fetch PC and issues pipelined reads to instruction memory over a read/waitrequest/readdatavalid interface. Returned instructions are buffered in a small FIFO, and each cycle one is handed to the IF/ID register that produces InstrD/PCD/PCPlus4D. It honours the global backend stall (o_p_waitrequest) and branch redirects from Execute (PCSrcE/PCTargetE), flushing the FIFO and discarding stale in-flight responses.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/fetch_fifo.sv | 65 ++++++
 rtl/fetch_cycle.sv | 132 +++++++++++++
 tb/tb_fetch_cycle.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch-buffer entry layout.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory response path and the IF/ID register.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output fetch_entry_t     rd_data_c,
  output logic [CNT_W-1:0] count,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_n;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    do_pop  = pop & ~empty;
    do_push = push & ~flush & ((count != CNT_W'(DEPTH)) | do_pop);
    count_n = count + CNT_W'(do_push) - CNT_W'(do_pop);
    if (flush) count_n = '0;
  end

  // Pointer/occupancy state; flush dominates any push in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      empty  <= 1'b1;
    end else begin
      count <= count_n;
      empty <= (count_n == '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= next_ptr(wr_ptr);
        if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign rd_data_c = mem[rd_ptr];

endmodule

// File: rtl/fetch_cycle.sv
// Fetch stage: credit-limited pipelined imem reads, redirect with stale-response
// discard, and the IF/ID register feeding decode.
module fetch_cycle
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        o_p_waitrequest,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        im_read,
  output logic [31:0] im_addr,
  input  logic        im_waitrequest,
  input  logic        im_readdatavalid,
  input  logic [31:0] im_readdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [XLEN-1:0]  pc_f, pc_f_n;
  logic [XLEN-1:0]  resp_pc, resp_pc_n;
  logic [CNT_W-1:0] outstanding, outstanding_n;
  logic [CNT_W-1:0] discard, discard_n;
  logic [CNT_W-1:0] count_n;
  logic             read_n;
  logic [XLEN-1:0]  instr_n, pcd_n, pcp4_n;
  logic             valid_n;

  logic             accept, resp, push, pop;
  fetch_entry_t     push_entry, head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_empty;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (PCSrcE),
    .rd_data_c (head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  always_comb begin
    accept           = im_read & ~im_waitrequest;
    // Responses with nothing outstanding are protocol errors and are ignored.
    resp             = im_readdatavalid & (outstanding != '0);
    push             = resp & (discard == '0);
    pop              = ~PCSrcE & ~o_p_waitrequest & ~fifo_empty;
    push_entry.instr = im_readdata;
    push_entry.pc    = resp_pc;

    outstanding_n = outstanding + CNT_W'(accept) - CNT_W'(resp);
    count_n       = PCSrcE ? '0 : fifo_count + CNT_W'(push) - CNT_W'(pop);
    // im_read is registered from next-state so it never depends on inputs combinationally.
    read_n        = (SUM_W'(outstanding_n) + SUM_W'(count_n)) < SUM_W'(FIFO_DEPTH);

    pc_f_n    = pc_f;
    resp_pc_n = resp_pc;
    discard_n = discard;
    if (PCSrcE) begin
      pc_f_n    = PCTargetE;
      resp_pc_n = PCTargetE;
      discard_n = outstanding_n;
    end else begin
      if (accept) pc_f_n = pc_f + XLEN'(4);
      if (resp) begin
        if (discard != '0) discard_n = discard - CNT_W'(1);
        else               resp_pc_n = resp_pc + XLEN'(4);
      end
    end

    instr_n = InstrD;
    pcd_n   = PCD;
    pcp4_n  = PCPlus4D;
    valid_n = ValidD;
    if (PCSrcE) begin
      instr_n = NOP_INSTR;
      valid_n = 1'b0;
    end else if (!o_p_waitrequest) begin
      if (!fifo_empty) begin
        instr_n = head.instr;
        pcd_n   = head.pc;
        pcp4_n  = head.pc + XLEN'(4);
        valid_n = 1'b1;
      end else begin
        instr_n = NOP_INSTR;
        valid_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_f        <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      im_read     <= 1'b0;
      InstrD      <= NOP_INSTR;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
    end else begin
      pc_f        <= pc_f_n;
      resp_pc     <= resp_pc_n;
      outstanding <= outstanding_n;
      discard     <= discard_n;
      im_read     <= read_n;
      InstrD      <= instr_n;
      PCD         <= pcd_n;
      PCPlus4D    <= pcp4_n;
      ValidD      <= valid_n;
    end
  end

  assign im_addr = pc_f;

  resp_has_credit: assert property (@(posedge clk) disable iff (!rst)
    im_readdatavalid |-> (outstanding != '0));

endmodule

// File: tb/tb_fetch_cycle.sv
// Directed bench for fetch_cycle with a latency-configurable in-order memory model.
module tb_fetch_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_p_waitrequest;
  logic        PCSrcE;
  logic [31:0] PCTargetE;
  logic        im_read;
  logic [31:0] im_addr;
  logic        im_waitrequest;
  logic        im_readdatavalid;
  logic [31:0] im_readdata;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic        ValidD;

  int total = 0;
  int bad   = 0;

  int unsigned lat = 1;
  int unsigned edge_no = 0;

  typedef struct {
    logic [31:0] addr;
    int unsigned ready;
  } pend_t;
  pend_t q[$];

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] TAG = 32'hA000_0000;

  fetch_cycle dut (
    .clk              (clk),
    .rst              (rst),
    .o_p_waitrequest  (o_p_waitrequest),
    .PCSrcE           (PCSrcE),
    .PCTargetE        (PCTargetE),
    .im_read          (im_read),
    .im_addr          (im_addr),
    .im_waitrequest   (im_waitrequest),
    .im_readdatavalid (im_readdatavalid),
    .im_readdata      (im_readdata),
    .InstrD           (InstrD),
    .PCD              (PCD),
    .PCPlus4D         (PCPlus4D),
    .ValidD           (ValidD)
  );

  always #5 clk = ~clk;

  // Memory: record accepted reads at the edge, answer in order after lat edges.
  always @(posedge clk) begin
    edge_no++;
    if (!rst) q.delete();
    else if (im_read && !im_waitrequest) q.push_back('{addr: im_addr, ready: edge_no + lat});
  end

  always @(negedge clk) begin
    im_readdatavalid = 1'b0;
    im_readdata      = 32'h0;
    if (rst && q.size() > 0 && q[0].ready <= edge_no + 1) begin
      im_readdatavalid = 1'b1;
      im_readdata      = q[0].addr | TAG;
      void'(q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc);
    chk({tag, ".valid"}, {31'b0, ValidD}, {31'b0, v});
    chk({tag, ".instr"}, InstrD, v ? (pc | TAG) : NOP);
    if (v) begin
      chk({tag, ".pcd"}, PCD, pc);
      chk({tag, ".pcp4"}, PCPlus4D, pc + 32'd4);
    end
  endtask

  task automatic do_reset();
    rst             = 1'b0;
    o_p_waitrequest = 1'b0;
    PCSrcE          = 1'b0;
    PCTargetE       = 32'h0;
    im_waitrequest  = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  initial begin
    rst              = 1'b0;
    o_p_waitrequest  = 1'b0;
    PCSrcE           = 1'b0;
    PCTargetE        = 32'h0;
    im_waitrequest   = 1'b0;
    im_readdatavalid = 1'b0;
    im_readdata      = 32'h0;

    // Reset state and first request.
    repeat (2) tick();
    chk("rst.valid", {31'b0, ValidD}, 32'd0);
    chk("rst.instr", InstrD, NOP);
    chk("rst.read", {31'b0, im_read}, 32'd0);
    chk("rst.pcd", PCD, 32'h0);
    chk("rst.pcp4", PCPlus4D, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("c0.read", {31'b0, im_read}, 32'd1);
    chk("c0.addr", im_addr, 32'h0);

    // Zero-wait stream: first valid in cycle 3.
    tick();
    chk("c1.valid", {31'b0, ValidD}, 32'd0);
    tick();
    chk("c2.valid", {31'b0, ValidD}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stream", 1'b1, 32'(4 * i));
    end

    // Backend stall for 6 cycles: outputs frozen, requests throttled.
    o_p_waitrequest = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk_out("stall", 1'b1, 32'h8);
      if (k >= 2) chk("stall.read", {31'b0, im_read}, 32'd0);
    end
    o_p_waitrequest = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out("resume", 1'b1, 32'(12 + 4 * i));
    end

    // Redirect with two stale reads in flight at latency 3.
    lat = 3;
    do_reset();
    chk("rd.c0addr", im_addr, 32'h0);
    tick();
    tick();
    chk("rd.c2addr", im_addr, 32'h8);
    im_waitrequest = 1'b1;
    PCSrcE         = 1'b1;
    PCTargetE      = 32'h100;
    tick();
    chk_out("rd.bubble", 1'b0, 32'h0);
    chk("rd.retarget", im_addr, 32'h100);
    chk("rd.read", {31'b0, im_read}, 32'd1);
    PCSrcE         = 1'b0;
    im_waitrequest = 1'b0;
    for (int k = 4; k <= 7; k++) begin
      tick();
      chk("rd.gap", {31'b0, ValidD}, 32'd0);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("rd.new", 1'b1, 32'(32'h100 + 4 * i));
    end

    // Memory waitrequest holds the address for 3 cycles.
    lat = 1;
    do_reset();
    tick();
    tick();
    chk("wr.c2addr", im_addr, 32'h8);
    im_waitrequest = 1'b1;
    for (int k = 3; k <= 5; k++) begin
      tick();
      chk("wr.hold", im_addr, 32'h8);
      chk("wr.read", {31'b0, im_read}, 32'd1);
    end
    chk_out("wr.bubble", 1'b0, 32'h0);
    chk("wr.pcd_keep", PCD, 32'h4);
    chk("wr.pcp4_keep", PCPlus4D, 32'h8);
    im_waitrequest = 1'b0;
    tick();
    chk("wr.accepted", im_addr, 32'hC);
    chk("wr.c6valid", {31'b0, ValidD}, 32'd0);
    tick();
    chk("wr.c7valid", {31'b0, ValidD}, 32'd0);
    tick();
    chk_out("wr.c8", 1'b1, 32'h8);

    // Redirect while the backend is stalled.
    do_reset();
    repeat (4) tick();
    chk_out("rs.c4", 1'b1, 32'h4);
    o_p_waitrequest = 1'b1;
    tick();
    chk_out("rs.c5", 1'b1, 32'h4);
    PCSrcE    = 1'b1;
    PCTargetE = 32'h200;
    tick();
    chk_out("rs.bubble", 1'b0, 32'h0);
    chk("rs.addr", im_addr, 32'h200);
    PCSrcE = 1'b0;
    tick();
    chk_out("rs.c7", 1'b0, 32'h0);
    tick();
    chk_out("rs.c8", 1'b0, 32'h0);
    o_p_waitrequest = 1'b0;
    tick();
    chk_out("rs.c9", 1'b1, 32'h200);
    tick();
    chk_out("rs.c10", 1'b1, 32'h204);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
